// File: rtl/cb_rd_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// cb_rd_arbiter_pkg - core-bus types shared by the read arbiter slice. Rev 1.0
//==============================================================================
package cb_rd_arbiter_pkg;

  typedef enum logic {CB_MST_INSTR = 1'b0, CB_MST_LSU = 1'b1} cb_mst_id_t;

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} arb_state_t;

  localparam int CB_ARB_MAX_OUTST_DEF = 4;

  typedef struct packed {
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic        rd_addr_valid;
    logic        rd_ready;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic        wr_addr_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_data_valid;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic [31:0] rd_data;
    logic [1:0]  rd_resp;
    logic        rd_valid;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic        wr_resp_valid;
    logic        wr_resp_error;
  } s_cb_miso_t;

  function automatic cb_mst_id_t other_mst(input cb_mst_id_t id);
    return (id == CB_MST_INSTR) ? CB_MST_LSU : CB_MST_INSTR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cb_rd_arbiter_id_fifo.sv
`default_nettype none
//==============================================================================
// cb_id_fifo - small FIFO holding the issuer ID of each outstanding read. Rev 1.0
//==============================================================================
module cb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cb_rd_arbiter.sv
`default_nettype none
//==============================================================================
// cb_rd_arbiter - fetch/LSU read arbiter with in-order response routing. Rev 1.0
//==============================================================================
module cb_rd_arbiter
  import cb_rd_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = CB_ARB_MAX_OUTST_DEF,
  parameter bit FIXED_PRIO      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  s_cb_mosi_t instr_mosi_i,
  output s_cb_miso_t instr_miso_o,
  input  s_cb_mosi_t lsu_mosi_i,
  output s_cb_miso_t lsu_miso_o,
  output s_cb_mosi_t cb_mosi_o,
  input  s_cb_miso_t cb_miso_i,
  output logic       rd_unexp_o
);

  arb_state_t state, state_nxt;
  cb_mst_id_t lock_gnt, lock_gnt_nxt;
  cb_mst_id_t last, last_nxt;
  cb_mst_id_t gnt;
  cb_mst_id_t head;
  logic       rst_q;
  logic       blk;
  logic       req_i, req_l;
  logic       gnt_valid;
  logic       addr_hs;
  logic       rd_ready;
  logic       fifo_pop;
  logic       fifo_full, fifo_empty;
  logic [0:0] fifo_dout;
  logic       unused_instr_wr;

  // Handshake outputs stay quiet during reset and for one cycle after it.
  always_ff @(posedge clk) rst_q <= rst;
  assign blk = rst | rst_q;

  assign req_i = instr_mosi_i.rd_addr_valid;
  assign req_l = lsu_mosi_i.rd_addr_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_UNLOCKED;
      lock_gnt <= CB_MST_INSTR;
      last     <= CB_MST_INSTR;
    end else begin
      state    <= state_nxt;
      lock_gnt <= lock_gnt_nxt;
      last     <= last_nxt;
    end
  end

  always_comb begin
    gnt          = CB_MST_INSTR;
    state_nxt    = state;
    lock_gnt_nxt = lock_gnt;
    last_nxt     = last;
    if (state == ST_LOCKED)  gnt = lock_gnt;
    else if (req_i && req_l) gnt = FIXED_PRIO ? CB_MST_LSU : other_mst(last);
    else if (req_l)          gnt = CB_MST_LSU;
    gnt_valid = ((gnt == CB_MST_LSU) ? req_l : req_i) & ~fifo_full & ~blk;
    addr_hs   = gnt_valid & cb_miso_i.rd_addr_ready;
    if (addr_hs) begin
      state_nxt = ST_UNLOCKED;
      last_nxt  = gnt;
    end else if (gnt_valid) begin
      // Address was offered but not taken: hold this grant until it is.
      state_nxt    = ST_LOCKED;
      lock_gnt_nxt = gnt;
    end
  end

  assign head     = cb_mst_id_t'(fifo_dout);
  assign rd_ready = fifo_empty ? 1'b1
                  : ((head == CB_MST_LSU) ? lsu_mosi_i.rd_ready : instr_mosi_i.rd_ready);
  assign fifo_pop   = ~fifo_empty & cb_miso_i.rd_valid & rd_ready;
  assign rd_unexp_o = fifo_empty & cb_miso_i.rd_valid;

  cb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (addr_hs),
    .pop   (fifo_pop),
    .din   (gnt),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    cb_mosi_o    = '0;
    instr_miso_o = '0;
    lsu_miso_o   = '0;

    cb_mosi_o.rd_addr       = (gnt == CB_MST_LSU) ? lsu_mosi_i.rd_addr : instr_mosi_i.rd_addr;
    cb_mosi_o.rd_size       = (gnt == CB_MST_LSU) ? lsu_mosi_i.rd_size : instr_mosi_i.rd_size;
    cb_mosi_o.rd_addr_valid = gnt_valid;
    cb_mosi_o.rd_ready      = rd_ready;
    instr_miso_o.rd_addr_ready = gnt_valid & (gnt == CB_MST_INSTR) & cb_miso_i.rd_addr_ready;
    lsu_miso_o.rd_addr_ready   = gnt_valid & (gnt == CB_MST_LSU) & cb_miso_i.rd_addr_ready;

    if (!fifo_empty && !blk) begin
      if (head == CB_MST_LSU) begin
        lsu_miso_o.rd_valid = cb_miso_i.rd_valid;
        lsu_miso_o.rd_data  = cb_miso_i.rd_data;
        lsu_miso_o.rd_resp  = cb_miso_i.rd_resp;
      end else begin
        instr_miso_o.rd_valid = cb_miso_i.rd_valid;
        instr_miso_o.rd_data  = cb_miso_i.rd_data;
        instr_miso_o.rd_resp  = cb_miso_i.rd_resp;
      end
    end

    cb_mosi_o.wr_addr       = lsu_mosi_i.wr_addr;
    cb_mosi_o.wr_size       = lsu_mosi_i.wr_size;
    cb_mosi_o.wr_addr_valid = lsu_mosi_i.wr_addr_valid & ~blk;
    cb_mosi_o.wr_data       = lsu_mosi_i.wr_data;
    cb_mosi_o.wr_strobe     = lsu_mosi_i.wr_strobe;
    cb_mosi_o.wr_data_valid = lsu_mosi_i.wr_data_valid & ~blk;
    cb_mosi_o.wr_resp_ready = lsu_mosi_i.wr_resp_ready;
    lsu_miso_o.wr_addr_ready = cb_miso_i.wr_addr_ready & ~blk;
    lsu_miso_o.wr_data_ready = cb_miso_i.wr_data_ready & ~blk;
    lsu_miso_o.wr_resp_valid = cb_miso_i.wr_resp_valid & ~blk;
    lsu_miso_o.wr_resp_error = cb_miso_i.wr_resp_error;
  end

  // Fetch never writes.
  assign unused_instr_wr = ^{instr_mosi_i.wr_addr, instr_mosi_i.wr_size,
                             instr_mosi_i.wr_addr_valid, instr_mosi_i.wr_data,
                             instr_mosi_i.wr_strobe, instr_mosi_i.wr_data_valid,
                             instr_mosi_i.wr_resp_ready};

`ifndef SYNTHESIS
  a_locked_req_held: assert property (@(posedge clk) disable iff (rst)
    (state == ST_LOCKED) |-> ((lock_gnt == CB_MST_LSU) ? req_l : req_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cb_rd_arbiter.sv
`default_nettype none
//==============================================================================
// tb_cb_rd_arbiter - directed and randomized checks of the read arbiter. Rev 1.0
//==============================================================================
module tb_cb_rd_arbiter;
  import cb_rd_arbiter_pkg::*;

  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  s_cb_mosi_t instr_mosi, lsu_mosi, cb_mosi;
  s_cb_miso_t instr_miso, lsu_miso, cb_miso;
  logic       rd_unexp;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  cb_rd_arbiter #(
    .MAX_OUTSTANDING (MAXO),
    .FIXED_PRIO      (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_mosi_i (instr_mosi),
    .instr_miso_o (instr_miso),
    .lsu_mosi_i   (lsu_mosi),
    .lsu_miso_o   (lsu_miso),
    .cb_mosi_o    (cb_mosi),
    .cb_miso_i    (cb_miso),
    .rd_unexp_o   (rd_unexp)
  );

  task automatic do_reset();
    rst = 1'b1;
    instr_mosi = '0;
    lsu_mosi   = '0;
    cb_miso    = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [8:0] got;
    rst = 1'b1;
    instr_mosi = '0; lsu_mosi = '0; cb_miso = '0;
    instr_mosi.rd_addr_valid = 1'b1; lsu_mosi.rd_addr_valid = 1'b1;
    lsu_mosi.wr_addr_valid = 1'b1; lsu_mosi.wr_data_valid = 1'b1;
    lsu_mosi.wr_resp_ready = 1'b1; lsu_mosi.rd_ready = 1'b1;
    cb_miso.rd_addr_ready = 1'b1; cb_miso.wr_addr_ready = 1'b1;
    cb_miso.wr_data_ready = 1'b1; cb_miso.wr_resp_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) rst = 1'b0;
      @(negedge clk);
      got = {cb_mosi.rd_addr_valid, instr_miso.rd_addr_ready, lsu_miso.rd_addr_ready,
             cb_mosi.wr_addr_valid, cb_mosi.wr_data_valid, lsu_miso.wr_addr_ready,
             lsu_miso.wr_data_ready, lsu_miso.wr_resp_valid, cb_mosi.wr_resp_ready};
      tests++;
      if (got !== ((c < 2) ? 9'b000000001 : 9'b101111111)) begin
        fails++;
        $display("FAIL reset_outputs phase%0d: got %b want %b", c, got,
                 (c < 2) ? 9'b000000001 : 9'b101111111);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_round_robin();
    logic want_l;
    do_reset();
    instr_mosi.rd_addr = 32'h1000; instr_mosi.rd_addr_valid = 1'b1;
    lsu_mosi.rd_addr   = 32'h2000; lsu_mosi.rd_addr_valid   = 1'b1;
    cb_miso.rd_addr_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      want_l = ((c % 2) == 0);
      @(negedge clk);
      tests++;
      if ({cb_mosi.rd_addr_valid, lsu_miso.rd_addr_ready, instr_miso.rd_addr_ready} !== {1'b1, want_l, !want_l}
          || cb_mosi.rd_addr !== (want_l ? 32'h2000 : 32'h1000)) begin
        fails++;
        $display("FAIL rr_grant c%0d: got addr %h l_rdy %b i_rdy %b want lsu=%b", c,
                 cb_mosi.rd_addr, lsu_miso.rd_addr_ready, instr_miso.rd_addr_ready, want_l);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    tests++;
    if ({cb_mosi.rd_addr_valid, instr_miso.rd_addr_ready, lsu_miso.rd_addr_ready} !== 3'b000) begin
      fails++;
      $display("FAIL rr_full: got %b want 000",
               {cb_mosi.rd_addr_valid, instr_miso.rd_addr_ready, lsu_miso.rd_addr_ready});
    end
  endtask

  task automatic test_lock();
    do_reset();
    instr_mosi.rd_addr = 32'h100; instr_mosi.rd_addr_valid = 1'b1;
    lsu_mosi.rd_addr   = 32'h200;
    for (int c = 0; c < 4; c++) begin
      lsu_mosi.rd_addr_valid = (c >= 1);
      cb_miso.rd_addr_ready  = (c == 3);
      @(negedge clk);
      tests++;
      if (cb_mosi.rd_addr !== 32'h100 || cb_mosi.rd_addr_valid !== 1'b1
          || instr_miso.rd_addr_ready !== (c == 3) || lsu_miso.rd_addr_ready !== 1'b0) begin
        fails++;
        $display("FAIL lock_hold c%0d: got addr %h v %b i_rdy %b l_rdy %b want addr 100",
                 c, cb_mosi.rd_addr, cb_mosi.rd_addr_valid, instr_miso.rd_addr_ready,
                 lsu_miso.rd_addr_ready);
      end
      @(posedge clk); #1;
    end
    instr_mosi.rd_addr_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (cb_mosi.rd_addr !== 32'h200 || lsu_miso.rd_addr_ready !== 1'b1) begin
      fails++;
      $display("FAIL lock_next: got addr %h l_rdy %b want 200/1", cb_mosi.rd_addr,
               lsu_miso.rd_addr_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    do_reset();
    cb_miso.rd_addr_ready = 1'b1;
    instr_mosi.rd_addr = 32'h40; lsu_mosi.rd_addr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      instr_mosi.rd_addr_valid = ((k % 2) == 0);
      lsu_mosi.rd_addr_valid   = ((k % 2) == 1);
      @(negedge clk);
      tests++;
      if (cb_mosi.rd_addr_valid !== 1'b1 || cb_mosi.rd_addr !== (((k % 2) == 0) ? 32'h40 : 32'h80)) begin
        fails++;
        $display("FAIL full_fill k%0d: got v %b addr %h", k, cb_mosi.rd_addr_valid, cb_mosi.rd_addr);
      end
      @(posedge clk); #1;
    end
    instr_mosi.rd_addr_valid = 1'b1; lsu_mosi.rd_addr_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (instr_miso.rd_addr_ready !== 1'b0 || cb_mosi.rd_addr_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_block: got rdy %b v %b want 0/0", instr_miso.rd_addr_ready,
               cb_mosi.rd_addr_valid);
    end
    @(posedge clk); #1;
    cb_miso.rd_valid = 1'b1; cb_miso.rd_data = 32'h1234_5678; instr_mosi.rd_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({instr_miso.rd_valid, lsu_miso.rd_valid, instr_miso.rd_addr_ready} !== 3'b100
        || instr_miso.rd_data !== 32'h1234_5678) begin
      fails++;
      $display("FAIL full_pop: got iv %b lv %b i_rdy %b data %h want 1/0/0 12345678",
               instr_miso.rd_valid, lsu_miso.rd_valid, instr_miso.rd_addr_ready, instr_miso.rd_data);
    end
    @(posedge clk); #1;
    cb_miso.rd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (instr_miso.rd_addr_ready !== 1'b1) begin
      fails++;
      $display("FAIL full_regrant: got rdy %b want 1", instr_miso.rd_addr_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_routing();
    do_reset();
    cb_miso.rd_addr_ready = 1'b1;
    instr_mosi.rd_addr_valid = 1'b1;
    @(posedge clk); #1;
    instr_mosi.rd_addr_valid = 1'b0; lsu_mosi.rd_addr_valid = 1'b1;
    @(posedge clk); #1;
    lsu_mosi.rd_addr_valid = 1'b0;
    cb_miso.rd_valid = 1'b1; cb_miso.rd_data = 32'hAAAA_0001;
    instr_mosi.rd_ready = 1'b1; lsu_mosi.rd_ready = 1'b0;
    @(negedge clk);
    tests++;
    if ({instr_miso.rd_valid, lsu_miso.rd_valid, cb_mosi.rd_ready} !== 3'b101
        || instr_miso.rd_data !== 32'hAAAA_0001) begin
      fails++;
      $display("FAIL route_instr: got iv %b lv %b rr %b data %h", instr_miso.rd_valid,
               lsu_miso.rd_valid, cb_mosi.rd_ready, instr_miso.rd_data);
    end
    @(posedge clk); #1;
    cb_miso.rd_data = 32'hBBBB_0002;
    for (int c = 0; c < 3; c++) begin
      lsu_mosi.rd_ready = (c == 2);
      @(negedge clk);
      tests++;
      if ({instr_miso.rd_valid, lsu_miso.rd_valid, cb_mosi.rd_ready} !== {2'b01, (c == 2)}
          || lsu_miso.rd_data !== 32'hBBBB_0002) begin
        fails++;
        $display("FAIL route_lsu c%0d: got iv %b lv %b rr %b data %h", c, instr_miso.rd_valid,
                 lsu_miso.rd_valid, cb_mosi.rd_ready, lsu_miso.rd_data);
      end
      @(posedge clk); #1;
    end
    cb_miso.rd_data = 32'hDEAD_0003;
    @(negedge clk);
    tests++;
    if ({rd_unexp, cb_mosi.rd_ready, instr_miso.rd_valid, lsu_miso.rd_valid} !== 4'b1100) begin
      fails++;
      $display("FAIL unexp_pulse: got un %b rr %b iv %b lv %b want 1100", rd_unexp,
               cb_mosi.rd_ready, instr_miso.rd_valid, lsu_miso.rd_valid);
    end
    @(posedge clk); #1;
    cb_miso.rd_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (rd_unexp !== 1'b0) begin
      fails++;
      $display("FAIL unexp_end: got %b want 0", rd_unexp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    logic [31:0] wd;
    do_reset();
    cb_miso.rd_addr_ready = 1'b1; instr_mosi.rd_addr_valid = 1'b1;
    @(posedge clk); #1;
    instr_mosi.rd_addr_valid = 1'b0;
    wd = $urandom;
    lsu_mosi.wr_addr = 32'h8000_0004; lsu_mosi.wr_data = wd; lsu_mosi.wr_strobe = 4'b0011;
    lsu_mosi.wr_addr_valid = 1'b1; lsu_mosi.wr_data_valid = 1'b1; lsu_mosi.wr_resp_ready = 1'b1;
    cb_miso.wr_addr_ready = 1'b1; cb_miso.wr_data_ready = 1'b0;
    cb_miso.wr_resp_valid = 1'b1; cb_miso.wr_resp_error = 1'b1;
    @(negedge clk);
    tests++;
    if (cb_mosi.wr_addr !== 32'h8000_0004 || cb_mosi.wr_data !== wd || cb_mosi.wr_strobe !== 4'b0011
        || {cb_mosi.wr_addr_valid, cb_mosi.wr_data_valid, cb_mosi.wr_resp_ready} !== 3'b111) begin
      fails++;
      $display("FAIL wr_fwd: got addr %h data %h strb %b want 80000004 %h 0011",
               cb_mosi.wr_addr, cb_mosi.wr_data, cb_mosi.wr_strobe, wd);
    end
    tests++;
    if ({lsu_miso.wr_addr_ready, lsu_miso.wr_data_ready, lsu_miso.wr_resp_valid,
         lsu_miso.wr_resp_error} !== 4'b1011
        || {instr_miso.wr_addr_ready, instr_miso.wr_resp_valid, instr_miso.wr_resp_error} !== 3'b000) begin
      fails++;
      $display("FAIL wr_back: got lsu %b instr %b want 1011 000",
               {lsu_miso.wr_addr_ready, lsu_miso.wr_data_ready, lsu_miso.wr_resp_valid, lsu_miso.wr_resp_error},
               {instr_miso.wr_addr_ready, instr_miso.wr_resp_valid, instr_miso.wr_resp_error});
    end
    @(posedge clk); #1;
  endtask

  // Randomized traffic against a queue-based model of issue order and fairness.
  task automatic test_random(input int ncyc);
    int          mq[$];
    logic [31:0] sq[$];
    logic        m_last, m_locked, m_lock_id;
    logic        i_pend, l_pend, s_valid;
    logic [31:0] i_addr, l_addr;
    logic        g, ev, ir, lr, full, owner, e_rr, e_iv, e_lv, pop;
    int          done;
    m_last = 1'b0; m_locked = 1'b0; m_lock_id = 1'b0;
    i_pend = 1'b0; l_pend = 1'b0; s_valid = 1'b0; done = 0;
    i_addr = '0; l_addr = '0;
    do_reset();
    repeat (ncyc) begin
      if (!i_pend && $urandom_range(2) == 0) begin i_pend = 1'b1; i_addr = $urandom & ~32'h3; end
      if (!l_pend && $urandom_range(2) == 0) begin l_pend = 1'b1; l_addr = $urandom & ~32'h3; end
      instr_mosi.rd_addr_valid = i_pend; instr_mosi.rd_addr = i_addr;
      lsu_mosi.rd_addr_valid   = l_pend; lsu_mosi.rd_addr   = l_addr;
      instr_mosi.rd_ready = 1'($urandom_range(1));
      lsu_mosi.rd_ready   = 1'($urandom_range(1));
      cb_miso.rd_addr_ready = 1'($urandom_range(1));
      if (!s_valid && sq.size() > 0 && $urandom_range(1) == 1) s_valid = 1'b1;
      cb_miso.rd_valid = s_valid;
      cb_miso.rd_data  = s_valid ? sq[0] : 32'h0;
      @(negedge clk);
      full = (mq.size() == MAXO);
      if (m_locked)              g = m_lock_id;
      else if (i_pend && l_pend) g = ~m_last;
      else                       g = l_pend;
      ev = !full && (g ? l_pend : i_pend);
      ir = ev && !g && cb_miso.rd_addr_ready;
      lr = ev && g && cb_miso.rd_addr_ready;
      tests++;
      if ({cb_mosi.rd_addr_valid, instr_miso.rd_addr_ready, lsu_miso.rd_addr_ready} !== {ev, ir, lr}
          || (ev && cb_mosi.rd_addr !== (g ? l_addr : i_addr))) begin
        fails++;
        $display("FAIL rnd_addr: got v/ir/lr %b addr %h want %b addr %h",
                 {cb_mosi.rd_addr_valid, instr_miso.rd_addr_ready, lsu_miso.rd_addr_ready},
                 cb_mosi.rd_addr, {ev, ir, lr}, g ? l_addr : i_addr);
      end
      if (mq.size() == 0) begin
        owner = 1'b0; e_rr = 1'b1; e_iv = 1'b0; e_lv = 1'b0;
      end else begin
        owner = (mq[0] != 0);
        e_rr  = owner ? lsu_mosi.rd_ready : instr_mosi.rd_ready;
        e_iv  = s_valid && !owner;
        e_lv  = s_valid && owner;
      end
      tests++;
      if ({instr_miso.rd_valid, lsu_miso.rd_valid, rd_unexp} !== {e_iv, e_lv, 1'b0}
          || (s_valid && cb_mosi.rd_ready !== e_rr)
          || (e_iv && instr_miso.rd_data !== sq[0]) || (e_lv && lsu_miso.rd_data !== sq[0])) begin
        fails++;
        $display("FAIL rnd_resp: got iv/lv/un %b rr %b want %b rr %b",
                 {instr_miso.rd_valid, lsu_miso.rd_valid, rd_unexp}, cb_mosi.rd_ready,
                 {e_iv, e_lv, 1'b0}, e_rr);
      end
      pop = (mq.size() > 0) && s_valid && e_rr;
      @(posedge clk);
      if (pop) begin
        void'(mq.pop_front());
        void'(sq.pop_front());
        s_valid = 1'b0;
        done++;
      end
      if (ir || lr) begin
        mq.push_back(int'(g));
        sq.push_back($urandom);
        m_last = g; m_locked = 1'b0;
        if (g) l_pend = 1'b0; else i_pend = 1'b0;
      end else if (ev) begin
        m_locked = 1'b1; m_lock_id = g;
      end
      #1;
    end
    tests++;
    if (done < 10) begin
      fails++;
      $display("FAIL rnd_progress: got %0d completed reads want >= 10", done);
    end
  endtask

  initial begin
    instr_mosi = '0; lsu_mosi = '0; cb_miso = '0;
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_routing();
    test_write();
    test_random(600);
    rst = 1'b1;
    instr_mosi = '0; lsu_mosi = '0; cb_miso = '0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
